// File: rtl/mem_lane_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mem_lane_unit
//  Purpose  : Data-memory access unit. Accepts one load/store at a time,
//             drives a request/acknowledge memory port with aligned address,
//             byte enables and lane-shifted write data, and returns the
//             extended load result. Access sizes run from byte up to
//             doubleword, the last only on a 64-bit bus.
//  Options  : MISALIGN_SPLIT_EN - when defined, misaligned accesses are
//             served. One that fits in a single bus word takes one beat.
//             One that crosses a word boundary takes two beats. When the
//             macro is undefined, misaligned accesses are rejected with an
//             error response.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_lane_unit #(
  parameter int DW = 32,
  parameter int AW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [1:0]      req_size,
  input  logic            req_signed,
  input  logic [AW-1:0]   req_addr,
  input  logic [DW-1:0]   req_wdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW/8-1:0] mem_be,
  output logic [DW-1:0]   mem_wdata,
  input  logic            mem_ack,
  input  logic [DW-1:0]   mem_rdata,
  output logic            rsp_valid,
  output logic [DW-1:0]   rsp_rdata,
  output logic            rsp_err
);

  localparam int NB = DW / 8;
  localparam int OW = $clog2(NB);
`ifdef MISALIGN_SPLIT_EN
  // The mask covers two bus words so that a crossing access can spill into
  // the second beat.
  localparam int MW = 2 * NB;
  localparam logic [OW:0] NB_L = (OW+1)'(NB);
`else
  localparam int MW = NB;
`endif

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BEAT1 = 2'd1;
  localparam logic [1:0] S_BEAT2 = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]    state_q, state_d;

  // Latched request fields
  logic          we_q, we_d;
  logic          sgn_q, sgn_d;
  logic [1:0]    size_q, size_d;
  logic [OW-1:0] off_q, off_d;
`ifdef MISALIGN_SPLIT_EN
  logic [DW-1:0] wdata_q, wdata_d;
  logic [MW-1:0] mask_q, mask_d;
  logic [DW-1:0] acc_q, acc_d;
`endif

  // Registered outputs
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [NB-1:0] mem_be_q, mem_be_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
  logic          rsp_err_q, rsp_err_d;

  // Request decode
  logic          w_accept;
  logic [OW-1:0] w_off;
  logic [3:0]    w_bytes;
  logic [3:0]    w_bm1;
  logic [MW-1:0] w_lowmask;
  logic [MW-1:0] w_mask;
  logic          w_illegal;
  logic          w_aligned;
  logic [OW+2:0] w_sh_req;

  // Beat datapath
  logic          w_beat_done;
  logic [OW+2:0] w_sh1;
  logic [DW-1:0] w_asm1;
  logic [DW-1:0] w_final;
  logic [DW-1:0] w_ext;
`ifdef MISALIGN_SPLIT_EN
  logic [OW:0]   w_noff;
  logic [OW+3:0] w_sh2;
  logic [DW-1:0] w_asm2;
`endif

  // Keep the low 8*bytes bits of d and fill the rest with zero or the sign.
  function automatic logic [DW-1:0] extend(input logic [DW-1:0] d,
                                           input logic [1:0] sz,
                                           input logic sg);
    logic [DW-1:0] res;
    int            nbits;
    logic          msb;
    nbits = 8 << sz;
    if (nbits > DW) nbits = DW;
    msb = d[nbits-1];
    for (int i = 0; i < DW; i++) begin
      res[i] = (i < nbits) ? d[i] : (sg & msb);
    end
    return res;
  endfunction

  // Decode the incoming request: size, offset, lane mask and legality.
  always_comb begin
    w_accept  = req_valid & req_ready;
    w_off     = req_addr[OW-1:0];
    w_bytes   = 4'd1 << req_size;
    w_bm1     = w_bytes - 4'd1;
    for (int i = 0; i < MW; i++) begin
      w_lowmask[i] = (i < int'(w_bytes));
    end
    w_mask    = w_lowmask << w_off;
    w_illegal = (NB == 4) && (req_size == 2'b11);
    w_aligned = ((4'(w_off) & w_bm1) == 4'd0);
    w_sh_req  = {w_off, 3'b000};
  end

  // Lane-shift returned read data and assemble the extended load result.
  always_comb begin
    w_beat_done = mem_req_q & mem_ack;
    w_sh1       = {off_q, 3'b000};
    w_asm1      = mem_rdata >> w_sh1;
`ifdef MISALIGN_SPLIT_EN
    w_noff      = NB_L - {1'b0, off_q};
    w_sh2       = {w_noff, 3'b000};
    w_asm2      = acc_q | (mem_rdata << w_sh2);
    w_final     = (state_q == S_BEAT2) ? w_asm2 : w_asm1;
`else
    w_final     = w_asm1;
`endif
    w_ext       = extend(w_final, size_q, sgn_q);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          if (w_illegal) begin
            state_d = S_RESP;
          end else if (w_aligned) begin
            state_d = S_BEAT1;
          end else begin
`ifdef MISALIGN_SPLIT_EN
            state_d = S_BEAT1;
`else
            state_d = S_RESP;
`endif
          end
        end
      end
      S_BEAT1: begin
        if (w_beat_done) begin
`ifdef MISALIGN_SPLIT_EN
          state_d = (|mask_q[MW-1:NB]) ? S_BEAT2 : S_RESP;
`else
          state_d = S_RESP;
`endif
        end
      end
`ifdef MISALIGN_SPLIT_EN
      S_BEAT2: begin
        if (w_beat_done) state_d = S_RESP;
      end
`endif
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values: launch beats, capture data, respond.
  always_comb begin
    we_d        = we_q;
    sgn_d       = sgn_q;
    size_d      = size_q;
    off_d       = off_q;
`ifdef MISALIGN_SPLIT_EN
    wdata_d     = wdata_q;
    mask_d      = mask_q;
    acc_d       = acc_q;
`endif
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          we_d   = req_we;
          sgn_d  = req_signed;
          size_d = req_size;
          off_d  = w_off;
`ifdef MISALIGN_SPLIT_EN
          wdata_d = req_wdata;
          mask_d  = w_mask;
          acc_d   = '0;
`endif
          if (state_d == S_BEAT1) begin
            mem_req_d   = 1'b1;
            mem_we_d    = req_we;
            mem_addr_d  = {req_addr[AW-1:OW], {OW{1'b0}}};
            mem_be_d    = w_mask[NB-1:0];
            mem_wdata_d = req_wdata << w_sh_req;
          end else begin
            // Rejected request: respond immediately, never touch memory.
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end
        end
      end
      S_BEAT1: begin
        if (w_beat_done) begin
`ifdef MISALIGN_SPLIT_EN
          acc_d = w_asm1;
`endif
          if (state_d == S_RESP) begin
            mem_req_d   = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = we_q ? '0 : w_ext;
          end
`ifdef MISALIGN_SPLIT_EN
          else begin
            // Second beat covers the bytes that spilled past the bus word.
            mem_addr_d  = mem_addr_q + AW'(NB);
            mem_be_d    = mask_q[MW-1:NB];
            mem_wdata_d = wdata_q >> w_sh2;
          end
`endif
        end
      end
`ifdef MISALIGN_SPLIT_EN
      S_BEAT2: begin
        if (w_beat_done) begin
          mem_req_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = we_q ? '0 : w_ext;
        end
      end
`endif
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q        <= 1'b0;
      sgn_q       <= 1'b0;
      size_q      <= 2'b00;
      off_q       <= '0;
`ifdef MISALIGN_SPLIT_EN
      wdata_q     <= '0;
      mask_q      <= '0;
      acc_q       <= '0;
`endif
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      we_q        <= we_d;
      sgn_q       <= sgn_d;
      size_q      <= size_d;
      off_q       <= off_d;
`ifdef MISALIGN_SPLIT_EN
      wdata_q     <= wdata_d;
      mask_q      <= mask_d;
      acc_q       <= acc_d;
`endif
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = (state_q == S_IDLE) & ~rst;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
`default_nettype wire
